// File: rtl/cnn_dense_sequencer.sv
// Dense-layer sequencer sitting beside an AXI-Stream interface block.
// A rising start launches one run: for each output neuron it walks the input
// buffer, MACs against ROM weights, adds the neuron bias, applies ReLU with
// saturation to the positive range and writes one word to the output buffer.
//
// Handshake: the interface raises axisif_start (only its rising edge seen in
// IDLE counts); axisif_done drops on the accepting edge and rises again once
// every neuron has been written. axisif_bufferOut_wr is a single-cycle strobe
// qualifying bufferOut_adr/bufferOut_data. Inside the datapath v_q marks that
// x_q and w_data hold a matching input/weight pair, so that product may be
// accumulated.
module cnn_dense_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int IN_DATA_NUM  = 8,
  parameter int OUT_DATA_NUM = 4,
  parameter int FRAC_BITS    = 8,
  parameter int ACC_WIDTH    = 72,
  localparam int IA_W = (IN_DATA_NUM > 1) ? $clog2(IN_DATA_NUM) : 1,
  localparam int OA_W = (OUT_DATA_NUM > 1) ? $clog2(OUT_DATA_NUM) : 1,
  localparam int WA_W = $clog2(OUT_DATA_NUM * IN_DATA_NUM + OUT_DATA_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  axisif_start,
  output logic                  axisif_done,
  output logic [IA_W-1:0]       axisif_bufferIn_adr,
  input  logic [DATA_WIDTH-1:0] axisif_bufferIn_data,
  output logic [OA_W-1:0]       axisif_bufferOut_adr,
  output logic [DATA_WIDTH-1:0] axisif_bufferOut_data,
  output logic                  axisif_bufferOut_wr,
  output logic [WA_W-1:0]       w_adr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    BIAS  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam logic [IA_W-1:0] LAST_I  = IA_W'(IN_DATA_NUM - 1);
  localparam logic [OA_W-1:0] LAST_N  = OA_W'(OUT_DATA_NUM - 1);
  localparam logic [WA_W-1:0] IN_K    = WA_W'(IN_DATA_NUM);
  localparam logic [WA_W-1:0] BIAS_K  = WA_W'(OUT_DATA_NUM * IN_DATA_NUM);
  localparam logic [DATA_WIDTH-1:0] POS_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  state_t                state_q, state_d;
  logic [OA_W-1:0]       n_q, n_d;
  logic [IA_W-1:0]       i_q, i_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic                  v_q, v_d;
  logic                  done_q, done_d;
  logic                  start_prev_q;
  logic [IA_W-1:0]       in_adr_q, in_adr_d;
  logic [WA_W-1:0]       w_adr_q, w_adr_d;
  logic                  start_q;

  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]    prod_ext;
  logic [ACC_WIDTH-1:0]    bias_ext;
  logic [ACC_WIDTH-1:0]    bias_al;
  logic [ACC_WIDTH-1:0]    sum;
  logic [ACC_WIDTH-1:0]    sum_sh;
  logic [DATA_WIDTH-1:0]   result;
  logic [WA_W-1:0]         w_mac_adr;
  logic [WA_W-1:0]         w_bias_adr;

  // Rising-edge detect of the start request
  assign start_q = axisif_start & ~start_prev_q;

  // ROM addresses for the current weight and the current neuron bias
  assign w_mac_adr  = WA_W'(n_q) * IN_K + WA_W'(i_q);
  assign w_bias_adr = BIAS_K + WA_W'(n_q);

  // Full-precision signed product (Q2*FRAC) and its sign extension to the acc
  assign prod     = {{DATA_WIDTH{x_q[DATA_WIDTH-1]}}, x_q}
                  * {{DATA_WIDTH{w_data[DATA_WIDTH-1]}}, w_data};
  assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

  // Bias arrives in Q(FRAC); shift it up to line up with the Q(2*FRAC) acc
  assign bias_ext = {{(ACC_WIDTH-DATA_WIDTH){w_data[DATA_WIDTH-1]}}, w_data};
  assign bias_al  = bias_ext << FRAC_BITS;
  assign sum      = acc_q + bias_al;
  assign sum_sh   = sum >> FRAC_BITS;

  // ReLU, then truncate back to Q(FRAC) and clip to the largest positive word
  always_comb begin
    result = '0;
    if (!sum[ACC_WIDTH-1]) begin
      if (|sum_sh[ACC_WIDTH-1:DATA_WIDTH-1]) result = POS_MAX;
      else                                   result = sum_sh[DATA_WIDTH-1:0];
    end
  end

  // Next-state, datapath updates and output decode
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    i_d      = i_q;
    acc_d    = acc_q;
    x_d      = x_q;
    v_d      = v_q;
    done_d   = done_q;
    in_adr_d = in_adr_q;
    w_adr_d  = w_adr_q;
    axisif_bufferOut_wr   = 1'b0;
    axisif_bufferOut_adr  = '0;
    axisif_bufferOut_data = '0;
    case (state_q)
      IDLE: begin
        if (start_q) begin
          state_d = MAC;
          done_d  = 1'b0;
          n_d     = '0;
          i_d     = '0;
          acc_d   = '0;
          v_d     = 1'b0;
        end
      end
      MAC: begin
        in_adr_d = i_q;
        w_adr_d  = w_mac_adr;
        x_d      = axisif_bufferIn_data;
        v_d      = 1'b1;
        if (v_q) acc_d = acc_q + prod_ext;
        if (i_q == LAST_I) state_d = BIAS;
        else               i_d = i_q + 1'b1;
      end
      BIAS: begin
        w_adr_d = w_bias_adr;
        if (v_q) acc_d = acc_q + prod_ext;
        v_d     = 1'b0;
        state_d = WRITE;
      end
      WRITE: begin
        axisif_bufferOut_wr   = 1'b1;
        axisif_bufferOut_adr  = n_q;
        axisif_bufferOut_data = result;
        if (n_q == LAST_N) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          n_d     = n_q + 1'b1;
          i_d     = '0;
          acc_d   = '0;
          state_d = MAC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Addresses follow the counters in MAC/BIAS and otherwise hold
  assign axisif_bufferIn_adr = in_adr_d;
  assign w_adr               = w_adr_d;
  assign axisif_done         = done_q;
  assign dbg_state_o         = state_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      i_q          <= '0;
      acc_q        <= '0;
      x_q          <= '0;
      v_q          <= 1'b0;
      done_q       <= 1'b1;
      start_prev_q <= 1'b0;
      in_adr_q     <= '0;
      w_adr_q      <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      i_q          <= i_d;
      acc_q        <= acc_d;
      x_q          <= x_d;
      v_q          <= v_d;
      done_q       <= done_d;
      start_prev_q <= axisif_start;
      in_adr_q     <= in_adr_d;
      w_adr_q      <= w_adr_d;
    end
  end

endmodule

// File: tb/tb_cnn_dense_sequencer.sv
// Directed bench for cnn_dense_sequencer with IN=8, OUT=4, FRAC=8.
module tb_cnn_dense_sequencer;

  localparam int DW   = 32;
  localparam int IN   = 8;
  localparam int OUT  = 4;
  localparam int IA_W = 3;
  localparam int OA_W = 2;
  localparam int WA_W = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            done;
  logic [IA_W-1:0] in_adr;
  logic [DW-1:0]   in_data;
  logic [OA_W-1:0] out_adr;
  logic [DW-1:0]   out_data;
  logic            wr;
  logic [WA_W-1:0] w_adr;
  logic [DW-1:0]   w_data;
  logic [1:0]      dbg_state;

  logic [DW-1:0] xbuf [IN];
  logic [DW-1:0] rom  [64];

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_dat [$];
  logic [DW-1:0] got_adr [$];
  int            got_cyc [$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int low_cycles;

  cnn_dense_sequencer dut (
    .clk                   (clk),
    .rst                   (rst),
    .axisif_start          (start),
    .axisif_done           (done),
    .axisif_bufferIn_adr   (in_adr),
    .axisif_bufferIn_data  (in_data),
    .axisif_bufferOut_adr  (out_adr),
    .axisif_bufferOut_data (out_data),
    .axisif_bufferOut_wr   (wr),
    .w_adr                 (w_adr),
    .w_data                (w_data),
    .dbg_state_o           (dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Input buffer is combinational, weight ROM is synchronous
  assign in_data = xbuf[in_adr];
  always @(posedge clk) w_data <= rom[w_adr];

  // Output-buffer write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (wr) begin
      got_dat.push_back(out_data);
      got_adr.push_back(DW'(out_adr));
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_x_all(input logic [DW-1:0] v);
    for (int k = 0; k < IN; k++) xbuf[k] = v;
  endtask

  task automatic set_neuron(input int n, input logic [DW-1:0] w, input logic [DW-1:0] b);
    for (int k = 0; k < IN; k++) rom[n*IN+k] = w;
    rom[OUT*IN+n] = b;
  endtask

  task automatic clear_mon();
    got_dat.delete();
    got_adr.delete();
    got_cyc.delete();
  endtask

  // Pulse start for one cycle and count done-low cycles until it returns
  task automatic launch_and_wait(output int lows);
    lows = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      lows++;
      @(negedge clk);
    end
  endtask

  // Full run against expected results already queued in exp_q
  task automatic run_and_check(input string tag);
    clear_mon();
    launch_and_wait(low_cycles);
    chk({tag, "_done"}, DW'(done), 1);
    chk({tag, "_lat"}, DW'(low_cycles), 40);
    chk({tag, "_nwr"}, DW'(got_dat.size()), 4);
    for (int k = 0; k < OUT; k++) begin
      if (k < got_dat.size()) begin
        chk($sformatf("%s_adr%0d", tag, k), got_adr[k], DW'(k));
        chk($sformatf("%s_dat%0d", tag, k), got_dat[k], exp_q.pop_front());
        if (k > 0) chk($sformatf("%s_gap%0d", tag, k), DW'(got_cyc[k] - got_cyc[k-1]), 10);
      end
    end
    exp_q.delete();
  endtask

  task automatic unit_config();
    set_x_all(32'd256);
    for (int n = 0; n < OUT; n++) set_neuron(n, 32'd256, 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 64; k++) rom[k] = '0;
    set_x_all('0);

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_done", DW'(done), 1);
    chk("rst_wr", DW'(wr), 0);
    chk("rst_oadr", DW'(out_adr), 0);
    chk("rst_odat", out_data, 0);
    chk("rst_iadr", DW'(in_adr), 0);
    chk("rst_wadr", DW'(w_adr), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Unit run: 8 * 1.0 * 1.0 = 8.0
    unit_config();
    repeat (4) exp_q.push_back(32'd2048);
    run_and_check("unit");

    // ReLU: negative weights and negative bias clamp to zero
    set_neuron(1, 32'hFFFF_FF00, 32'd0);
    set_neuron(2, 32'd0, 32'hFFFF_FFFB);
    exp_q.push_back(32'd2048);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd2048);
    run_and_check("relu");

    // Positive bias alone: 3.0
    set_neuron(2, 32'd0, 32'd768);
    exp_q.push_back(32'd2048);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd768);
    exp_q.push_back(32'd2048);
    run_and_check("bias");

    // Mixed: x[k]=k, sum x = 28
    for (int k = 0; k < IN; k++) xbuf[k] = DW'(k * 256);
    set_neuron(0, 32'd1, 32'd0);             // 28*256*1 >> 8 = 28
    set_neuron(1, 32'hFFFF_FFFF, 32'd0);     // negative -> 0
    set_neuron(2, 32'd100, 32'hFFFF_FED4);   // (716800 - 76800) >> 8 = 2500
    set_neuron(3, 32'd128, 32'd256);         // 14.0 + 1.0 = 15.0
    exp_q.push_back(32'd28);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd2500);
    exp_q.push_back(32'd3840);
    run_and_check("mix");

    // Saturation with the largest positive operands
    set_x_all(32'h7FFF_FFFF);
    for (int n = 0; n < OUT; n++) set_neuron(n, 32'h7FFF_FFFF, 32'd0);
    repeat (4) exp_q.push_back(32'h7FFF_FFFF);
    run_and_check("satp");

    // Saturation with the most negative operands (positive product)
    set_x_all(32'h8000_0000);
    for (int n = 0; n < OUT; n++) set_neuron(n, 32'h8000_0000, 32'd0);
    repeat (4) exp_q.push_back(32'h7FFF_FFFF);
    run_and_check("satn");

    // Start held high for 100 cycles runs exactly once
    unit_config();
    clear_mon();
    @(negedge clk) start = 1'b1;
    repeat (100) @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("hold_nwr", DW'(got_dat.size()), 4);
    chk("hold_done", DW'(done), 1);

    // A second pulse mid-run is dropped
    clear_mon();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int t = 0; t < 300 && !done; t++) @(negedge clk);
    repeat (20) @(negedge clk);
    chk("mid_nwr", DW'(got_dat.size()), 4);
    chk("mid_done", DW'(done), 1);

    // A pulse after done gives a second full run
    repeat (4) exp_q.push_back(32'd2048);
    run_and_check("again");

    // Reset mid-run aborts at once
    clear_mon();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_rst_busy", DW'(done), 0);
    rst = 1'b1;
    #1;
    chk("mrst_done", DW'(done), 1);
    chk("mrst_wr", DW'(wr), 0);
    chk("mrst_odat", out_data, 0);
    chk("mrst_wadr", DW'(w_adr), 0);
    chk("mrst_iadr", DW'(in_adr), 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst_nwr", DW'(got_dat.size()), 1);

    // Clean full run after the abort
    repeat (4) exp_q.push_back(32'd2048);
    run_and_check("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
